// File: rtl/motor_dir_sequencer_pkg.sv
// Shared definitions for the motor direction sequencer: direction codes,
// H-bridge pin patterns and FSM state encoding.
package motor_pkg;

  localparam logic [1:0] DIR_FWD   = 2'b00;
  localparam logic [1:0] DIR_REV   = 2'b11;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  localparam logic [3:0] TANK_OFF   = 4'b0000;
  localparam logic [3:0] TANK_FWD   = 4'b0110;
  localparam logic [3:0] TANK_REV   = 4'b1001;
  localparam logic [3:0] TANK_LEFT  = 4'b1010;
  localparam logic [3:0] TANK_RIGHT = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_BRAKE = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  function automatic logic [3:0] dir_pattern(input logic [1:0] dir);
    case (dir)
      DIR_FWD:   return TANK_FWD;
      DIR_REV:   return TANK_REV;
      DIR_LEFT:  return TANK_LEFT;
      DIR_RIGHT: return TANK_RIGHT;
      default:   return TANK_OFF;
    endcase
  endfunction

endpackage

// File: rtl/motor_dir_sequencer_ramp_tick_gen.sv
// Free-running ramp prescaler: counts 0..RAMP_DIV-1 and flags the wrap cycle.
// A clear restarts the count so the next tick lands RAMP_DIV clocks later.
module ramp_tick_gen
  import motor_pkg::*;
#(
  parameter int RAMP_DIV = 1000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST) && !clear;

endmodule

// File: rtl/motor_dir_sequencer.sv
// Direction/speed command sequencer for the tank H-bridge: ramps the shared
// duty and forces every reversal through brake and a bridge-off dead time.
module motor_dir_sequencer
  import motor_pkg::*;
#(
  parameter int DUTY_W      = 6,
  parameter int RAMP_DIV    = 1000,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              estop,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_dir,
  input  logic [DUTY_W-1:0] cmd_speed,
  output logic [DUTY_W-1:0] duty,
  output logic [3:0]        tank_dir,
  output logic              busy
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  // One LSB toward the target, clamped so the duty can never wrap.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    if (cur < tgt && cur != '1) return cur + 1'b1;
    if (cur > tgt && cur != '0) return cur - 1'b1;
    return cur;
  endfunction

  state_t            state, state_d;
  logic [DUTY_W-1:0] duty_d, target, target_d, pend_speed, pend_speed_d;
  logic [3:0]        tank_d;
  logic [1:0]        cur_dir, cur_dir_d, pend_dir, pend_dir_d;
  logic [DEAD_W-1:0] dead_cnt, dead_cnt_d;
  logic              ready_d, busy_d, accept, tick;

  assign accept = cmd_valid && cmd_ready && !estop;

  ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .clear  (accept),
    .tick   (tick)
  );

  always_comb begin
    state_d      = state;
    duty_d       = duty;
    tank_d       = tank_dir;
    cur_dir_d    = cur_dir;
    target_d     = target;
    pend_dir_d   = pend_dir;
    pend_speed_d = pend_speed;
    dead_cnt_d   = dead_cnt;
    if (estop) begin
      state_d      = ST_IDLE;
      duty_d       = '0;
      tank_d       = TANK_OFF;
      target_d     = '0;
      pend_speed_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && cmd_speed != '0) begin
            tank_d    = dir_pattern(cmd_dir);
            cur_dir_d = cmd_dir;
            target_d  = cmd_speed;
            state_d   = ST_RAMP;
          end
        end
        ST_RAMP, ST_HOLD: begin
          if (accept) begin
            if (cmd_dir == cur_dir) begin
              target_d = cmd_speed;
              state_d  = ST_RAMP;
            end else begin
              pend_dir_d   = cmd_dir;
              pend_speed_d = cmd_speed;
              target_d     = '0;
              state_d      = ST_BRAKE;
            end
          end else if (state == ST_RAMP) begin
            if (duty == target) begin
              if (target == '0) begin
                state_d = ST_IDLE;
                tank_d  = TANK_OFF;
              end else begin
                state_d = ST_HOLD;
              end
            end else if (tick) begin
              duty_d = step_toward(duty, target);
            end
          end
        end
        ST_BRAKE: begin
          if (duty == '0) begin
            tank_d     = TANK_OFF;
            dead_cnt_d = '0;
            state_d    = ST_DEAD;
          end else if (tick) begin
            duty_d = step_toward(duty, '0);
          end
        end
        ST_DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            cur_dir_d = pend_dir;
            target_d  = pend_speed;
            if (pend_speed != '0) begin
              tank_d  = dir_pattern(pend_dir);
              state_d = ST_RAMP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            dead_cnt_d = dead_cnt + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = !estop && (state_d == ST_IDLE || state_d == ST_RAMP || state_d == ST_HOLD);
    busy_d  = (state_d == ST_RAMP || state_d == ST_BRAKE || state_d == ST_DEAD);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      duty      <= '0;
      tank_dir  <= TANK_OFF;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      cur_dir   <= DIR_FWD;
      target    <= '0;
      dead_cnt  <= '0;
    end else begin
      state     <= state_d;
      duty      <= duty_d;
      tank_dir  <= tank_d;
      cmd_ready <= ready_d;
      busy      <= busy_d;
      cur_dir   <= cur_dir_d;
      target    <= target_d;
      dead_cnt  <= dead_cnt_d;
    end
  end

  // Pending command is only meaningful in BRAKE/DEAD, so it carries no reset.
  always_ff @(posedge clock) begin
    pend_dir   <= pend_dir_d;
    pend_speed <= pend_speed_d;
  end

endmodule
